// File: rtl/circular_buffer_fifo.sv
// Circular FIFO with push, pop and peek, used to queue warp records between load and dispatch.
// Define CIRCULAR_BUFFER_STATUS_EN to add fill_count plus sticky overflow/underflow outputs.
module circular_buffer_fifo #(
  parameter int SIZE  = 8,
  parameter int WIDTH = 35
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_buffer,
  input  logic                       pop_buffer,
  input  logic                       read_buffer,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       at_capacity,
  output logic                       is_empty
`ifdef CIRCULAR_BUFFER_STATUS_EN
  ,
  output logic [$clog2(SIZE+1)-1:0]  fill_count,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int CW = $clog2(SIZE + 1);
  localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(SIZE - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(SIZE);

  logic [WIDTH-1:0] mem [SIZE];

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q;

  logic pop_acc, read_acc, push_acc;

  // A pop frees a slot in the same cycle, so a push into a full buffer is accepted alongside it.
  always_comb begin
    pop_acc  = pop_buffer && (count_q != '0);
    read_acc = read_buffer && !pop_buffer && (count_q != '0);
    push_acc = push_buffer && ((count_q != FULL_CNT) || pop_acc);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_acc) begin
      head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
    end
    if (push_acc) begin
      tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
    end
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop_acc || read_acc) begin
        data_out_q <= mem[head_q];
      end
    end
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push_acc && !rst) begin
      mem[tail_q] <= data_in;
    end
  end

  assign data_out    = data_out_q;
  assign at_capacity = (count_q == FULL_CNT);
  assign is_empty    = (count_q == '0);

`ifdef CIRCULAR_BUFFER_STATUS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_buffer && !push_acc) begin
        overflow_q <= 1'b1;
      end
      if ((pop_buffer || read_buffer) && (count_q == '0)) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign fill_count = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
`endif

endmodule

// File: tb/tb_circular_buffer_fifo.sv
// Self-checking bench for circular_buffer_fifo: directed table, hand corner-case sequences
// and randomized traffic, all compared against a queue-based reference model.
module tb_circular_buffer_fifo;

  localparam int SIZE  = 8;
  localparam int WIDTH = 35;
  localparam int CW    = $clog2(SIZE + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             push_buffer, pop_buffer, read_buffer;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             at_capacity, is_empty;
`ifdef CIRCULAR_BUFFER_STATUS_EN
  logic [CW-1:0]    fill_count;
  logic             overflow, underflow;
`endif

  circular_buffer_fifo #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .push_buffer (push_buffer),
    .pop_buffer  (pop_buffer),
    .read_buffer (read_buffer),
    .data_in     (data_in),
    .data_out    (data_out),
    .at_capacity (at_capacity),
`ifdef CIRCULAR_BUFFER_STATUS_EN
    .fill_count  (fill_count),
    .overflow    (overflow),
    .underflow   (underflow),
`endif
    .is_empty    (is_empty)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the FIFO contents as a queue plus the last value handed out.
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] model_dout;
  bit               model_ovf, model_unf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, update the model at the edge, then compare.
  task automatic step(input bit r, input bit pu, input bit po, input bit rd,
                      input logic [WIDTH-1:0] d, input string tag);
    bit pop_ok, rd_ok, push_ok;
    rst = r; push_buffer = pu; pop_buffer = po; read_buffer = rd; data_in = d;
    @(posedge clk);
    if (r) begin
      model_q.delete();
      model_dout = '0;
      model_ovf  = 0;
      model_unf  = 0;
    end else begin
      pop_ok  = po && (model_q.size() > 0);
      rd_ok   = rd && !po && (model_q.size() > 0);
      push_ok = pu && ((model_q.size() < SIZE) || pop_ok);
      if ((po || rd) && model_q.size() == 0) model_unf = 1;
      if (pu && !push_ok) model_ovf = 1;
      if (pop_ok) model_dout = model_q.pop_front();
      else if (rd_ok) model_dout = model_q[0];
      if (push_ok) model_q.push_back(d);
    end
    #1;
    chk({tag, ".data_out"}, 64'(data_out), 64'(model_dout));
    chk({tag, ".is_empty"}, 64'(is_empty), 64'(model_q.size() == 0));
    chk({tag, ".at_capacity"}, 64'(at_capacity), 64'(model_q.size() == SIZE));
`ifdef CIRCULAR_BUFFER_STATUS_EN
    chk({tag, ".fill_count"}, 64'(fill_count), 64'(model_q.size()));
    chk({tag, ".overflow"}, 64'(overflow), 64'(model_ovf));
    chk({tag, ".underflow"}, 64'(underflow), 64'(model_unf));
`endif
    $display("[TB] %-10s rst=%0b push=%0b pop=%0b read=%0b din=0x%0h -> dout=0x%0h empty=%0b full=%0b",
             tag, r, pu, po, rd, d, data_out, is_empty, at_capacity);
  endtask

  typedef struct {
    bit               push, pop, read;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] exp_dout;
    bit               exp_empty, exp_full;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [WIDTH-1:0] vals[SIZE];
    logic [WIDTH-1:0] d;

    rst = 1'b1; push_buffer = 0; pop_buffer = 0; read_buffer = 0; data_in = '0;

    // Hand-derived expectations, independent of the model.
    vecs[0] = '{1, 0, 0, 35'h1_0000_0003, 35'h0,           0, 0};
    vecs[1] = '{1, 0, 0, 35'h2_0000_0005, 35'h0,           0, 0};
    vecs[2] = '{0, 1, 0, 35'h0,           35'h1_0000_0003, 0, 0};
    vecs[3] = '{0, 1, 0, 35'h0,           35'h2_0000_0005, 1, 0};
    vecs[4] = '{0, 1, 0, 35'h0,           35'h2_0000_0005, 1, 0};
    vecs[5] = '{0, 0, 1, 35'h0,           35'h2_0000_0005, 1, 0};
    vecs[6] = '{1, 0, 0, 35'h0_0000_000C, 35'h2_0000_0005, 0, 0};
    vecs[7] = '{0, 0, 1, 35'h0,           35'h0_0000_000C, 0, 0};
    vecs[8] = '{0, 1, 0, 35'h0,           35'h0_0000_000C, 1, 0};

    // Reset, idle, and a pop while empty.
    step(1, 0, 0, 0, '0, "reset");
    step(1, 0, 0, 0, '0, "reset");
    chk("reset.data_out_zero", 64'(data_out), 64'h0);
    chk("reset.is_empty", 64'(is_empty), 64'h1);
    chk("reset.at_capacity", 64'(at_capacity), 64'h0);
    step(0, 0, 0, 0, '0, "idle");
    step(0, 0, 1, 0, '0, "pop_empty");
    chk("pop_empty.data_out_zero", 64'(data_out), 64'h0);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      step(0, vecs[i].push, vecs[i].pop, vecs[i].read, vecs[i].din, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_dout", i), 64'(data_out), 64'(vecs[i].exp_dout));
      chk($sformatf("vec%0d.tbl_empty", i), 64'(is_empty), 64'(vecs[i].exp_empty));
      chk($sformatf("vec%0d.tbl_full", i), 64'(at_capacity), 64'(vecs[i].exp_full));
    end

    // Fill, drop a push of 0x7 when full, drain in order.
    for (int i = 0; i < SIZE; i++) begin
      vals[i] = 35'h4_0000_0100 + 35'(i * 17);
      step(0, 1, 0, 0, vals[i], "fill");
    end
    chk("fill.at_capacity", 64'(at_capacity), 64'h1);
    step(0, 1, 0, 0, 35'h7, "push_full");
    for (int i = 0; i < SIZE; i++) begin
      step(0, 0, 1, 0, '0, "drain");
      chk($sformatf("drain%0d.order", i), 64'(data_out), 64'(vals[i]));
    end
    chk("drain.is_empty", 64'(is_empty), 64'h1);

    // Wrap-around: push 6, pop 6, push 8, pop 8.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 35'(100 + i), "wrap_push6");
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, '0, "wrap_pop6");
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 35'(200 + i), "wrap_push8");
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0, '0, "wrap_pop8");
      chk($sformatf("wrap%0d.order", i), 64'(data_out), 64'(200 + i));
    end

    // Full + simultaneous push/pop: old head out, new entry comes out last.
    for (int i = 0; i < SIZE; i++) step(0, 1, 0, 0, 35'(300 + i), "refill");
    step(0, 1, 1, 0, 35'h5_AAAA_0001, "full_pp");
    chk("full_pp.old_head", 64'(data_out), 64'(300));
    chk("full_pp.still_full", 64'(at_capacity), 64'h1);
    for (int i = 0; i < SIZE; i++) step(0, 0, 1, 0, '0, "full_drain");
    chk("full_pp.A_last", 64'(data_out), 64'h5_AAAA_0001);

    // Empty + simultaneous push/pop: push only.
    step(0, 1, 1, 0, 35'h3_BBBB_0002, "empty_pp");
    chk("empty_pp.not_empty", 64'(is_empty), 64'h0);
    step(0, 0, 1, 0, '0, "empty_pp_pop");
    chk("empty_pp.B", 64'(data_out), 64'h3_BBBB_0002);

    // Reset mid-sequence overrides a push/pop in the same cycle.
    step(0, 1, 0, 0, 35'h11, "pre_rst");
    step(0, 1, 0, 0, 35'h22, "pre_rst");
    step(0, 0, 1, 0, '0, "pre_rst");
    step(1, 1, 1, 0, 35'h33, "mid_rst");
    chk("mid_rst.data_out_zero", 64'(data_out), 64'h0);
    chk("mid_rst.is_empty", 64'(is_empty), 64'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      d = 35'({$urandom(), $urandom()});
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 20), d, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/circular_buffer_fifo.md
Name: circular_buffer_fifo

Overview:
- Synchronous circular FIFO of SIZE entries, each WIDTH bits wide.
- Used by the warp scheduler to queue {start_pc, thread_count} warp records between loading and dispatch.
- Supports push, pop (read-and-remove) and read (peek without removal).
- Provides full/empty status flags.

Parameters:
- SIZE, 8, number of entries; any integer >= 2; pointers wrap explicitly at SIZE-1, so powers of two are not required.
- WIDTH, 35, entry width in bits (32-bit PC + LOG2_THREAD_COUNT=3 thread-count bits).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- push_buffer  input  1  write data_in at tail this cycle.
- pop_buffer  input  1  load head entry into data_out and remove it.
- read_buffer  input  1  load head entry into data_out without removing it.
- data_in  input  WIDTH  entry to push.
- data_out  output  WIDTH  registered head entry captured by the last accepted pop/read.
- at_capacity  output  1  high when count == SIZE.
- is_empty  output  1  high when count == 0.

Behaviour:
- State: storage array mem[0..SIZE-1], head pointer, tail pointer, count (width clog2(SIZE+1)).
- Reset (rst=1 at clock edge):
  - head, tail, count cleared to 0; data_out cleared to 0.
  - Storage contents are don't-care.
  - Flags after reset: is_empty=1, at_capacity=0.
  - Reset overrides all other inputs in the same cycle, including mid-operation.
- Flags: at_capacity and is_empty are combinational decodes of the registered count, so they change the cycle after the push/pop that affects them.
- Push accepted when push_buffer=1 and (count<SIZE, or a pop is accepted in the same cycle):
  - mem[tail] <= data_in; tail <= (tail==SIZE-1) ? 0 : tail+1.
- Pop accepted when pop_buffer=1 and count>0:
  - data_out <= mem[head]; head advances with the same wrap rule.
- Read accepted when read_buffer=1, pop_buffer=0 and count>0:
  - data_out <= mem[head]; head and count unchanged.
  - pop_buffer has priority over read_buffer.
- Count update:
  - +1 on push only; -1 on pop only.
  - Unchanged when both push and pop are accepted, or when neither is.
- Latency: data_out reflects the popped/read entry on the cycle after the request edge (one-cycle registered read). Requesters sample data_out one cycle after asserting pop/read.
- Ignored requests (no state change, data_out holds its previous value, no error):
  - Push when full with no simultaneous pop.
  - Pop or read when empty.
- Simultaneous events:
  - Push+pop when empty: push accepted, pop ignored, count becomes 1.
  - Push+pop when full: both accepted, data_out gets the old head, the new entry is written at tail, count stays SIZE.
- Ordering: strict FIFO across pointer wrap-around.
- data_out holds its value indefinitely between accepted pop/read operations.

Optional Feature:
- Macro: CIRCULAR_BUFFER_STATUS_EN.
- When defined, three extra outputs are added:
  - fill_count (clog2(SIZE+1) bits): current count.
  - overflow (1 bit): sticky; set when a push is dropped because the buffer is full.
  - underflow (1 bit): sticky; set when a pop or read is requested while empty.
  - Both sticky flags clear only on rst.
- When not defined: those ports and their logic do not exist; core behaviour is identical in both builds.

Test Plan:
- Reset, then idle: is_empty=1, at_capacity=0, data_out=0; a pop while empty leaves data_out=0 and count=0 (underflow=1 if the feature is enabled).
- Push 0x1_0000_0003 then 0x2_0000_0005; pop twice on consecutive cycles -> data_out reads 0x1_0000_0003 then 0x2_0000_0005, each one cycle after its pop; is_empty=1 afterwards.
- Push 8 distinct values -> at_capacity=1; a 9th push with value 0x7 is dropped; 8 pops return the original 8 values in order, never 0x7.
- Wrap-around: push 6, pop 6, push 8, pop 8 -> correct order throughout; flags correct at each step.
- Full + simultaneous push/pop of value A -> data_out=old head, at_capacity stays 1, A is returned last; empty + push/pop of B -> count=1, next pop returns B.
- read_buffer on entry C -> data_out=C while count is unchanged; a following pop also returns C, and is_empty=1 when C was the only entry; assert rst mid-sequence -> empty with data_out=0 on the next cycle.
